// File: rtl/pwm_regbank.sv
// PWM output driven from a shadow/active register bank written over a byte-wide register port.
// Define PWM_PERIOD_START_EN to build the period_start pulse; otherwise it is tied low.
module pwm_regbank #(
  parameter int unsigned REGBITS = 2,
  parameter int unsigned CNTBITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REGBITS-1:0] regAddr,
  input  logic [7:0]         regData,
  input  logic               regDataValid,
  output logic               pwm_out,
  output logic               update_pending,
  output logic               period_start
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_invert, w_invert_nxt;
  logic                 r_pending, w_pending_nxt;
  logic                 r_pwm, w_pwm_nxt;
  logic [CNTBITS-1:0]   r_cnt, w_cnt_nxt;
  logic [CNTBITS-1:0]   r_shadow_duty, w_shadow_duty_nxt;
  logic [CNTBITS-1:0]   r_shadow_period, w_shadow_period_nxt;
  logic [CNTBITS-1:0]   r_active_duty, w_active_duty_nxt;
  logic [CNTBITS-1:0]   r_active_period, w_active_period_nxt;

  logic w_wr_duty_lo, w_wr_duty_hi, w_wr_per_hi, w_wr_ctrl, w_commit, w_wrap;

  assign w_wr_duty_lo = regDataValid && (regAddr == REGBITS'(0));
  assign w_wr_duty_hi = regDataValid && (regAddr == REGBITS'(1));
  assign w_wr_per_hi  = regDataValid && (regAddr == REGBITS'(2));
  assign w_wr_ctrl    = regDataValid && (regAddr == REGBITS'(3));
  assign w_commit     = w_wr_ctrl && regData[7];
  assign w_wrap       = (r_state == RUN) && (r_cnt == r_active_period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_invert        <= 1'b0;
      r_pending       <= 1'b0;
      r_pwm           <= 1'b0;
      r_cnt           <= '0;
      r_shadow_duty   <= '0;
      r_shadow_period <= '1;
      r_active_duty   <= '0;
      r_active_period <= '1;
    end else begin
      r_state         <= w_state_nxt;
      r_invert        <= w_invert_nxt;
      r_pending       <= w_pending_nxt;
      r_pwm           <= w_pwm_nxt;
      r_cnt           <= w_cnt_nxt;
      r_shadow_duty   <= w_shadow_duty_nxt;
      r_shadow_period <= w_shadow_period_nxt;
      r_active_duty   <= w_active_duty_nxt;
      r_active_period <= w_active_period_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_invert_nxt        = r_invert;
    w_pending_nxt       = r_pending;
    w_pwm_nxt           = r_pwm;
    w_cnt_nxt           = r_cnt;
    w_shadow_duty_nxt   = r_shadow_duty;
    w_shadow_period_nxt = r_shadow_period;
    w_active_duty_nxt   = r_active_duty;
    w_active_period_nxt = r_active_period;

    if (w_wr_duty_lo) w_shadow_duty_nxt[7:0]  = regData;
    if (w_wr_duty_hi) w_shadow_duty_nxt[15:8] = regData;
    if (w_wr_per_hi)  w_shadow_period_nxt     = {regData, 8'hFF};
    if (w_wr_ctrl) begin
      w_state_nxt  = regData[0] ? RUN : IDLE;
      w_invert_nxt = regData[1];
    end

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_pwm_nxt = r_invert;
        // No period is in flight while idle, so a commit written now is applied
        // on the same edge rather than left armed.
        if (r_pending || w_commit) begin
          w_active_duty_nxt   = r_shadow_duty;
          w_active_period_nxt = r_shadow_period;
          w_pending_nxt       = 1'b0;
        end
      end
      RUN: begin
        w_cnt_nxt = w_wrap ? '0 : r_cnt + CNTBITS'(1);
        w_pwm_nxt = (r_cnt < r_active_duty) ^ r_invert;
        // Only a commit already armed before the wrap edge is taken there.
        if (w_wrap && r_pending) begin
          w_active_duty_nxt   = r_shadow_duty;
          w_active_period_nxt = r_shadow_period;
          w_pending_nxt       = 1'b0;
        end else if (w_commit) begin
          w_pending_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign pwm_out        = r_pwm;
  assign update_pending = r_pending;

`ifdef PWM_PERIOD_START_EN
  logic r_wrap_d;
  logic r_pstart;

  // Delayed one stage so the pulse lines up with the pwm_out sample of cnt == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_d <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      r_wrap_d <= w_wrap;
      r_pstart <= r_wrap_d && (r_state == RUN);
    end
  end

  assign period_start = r_pstart;
`else
  assign period_start = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_regbank.sv
// Directed self-checking bench for pwm_regbank: reset, commit timing, wrap edge cases, invert and disable.
module tb_pwm_regbank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] regAddr;
  logic [7:0] regData;
  logic       regDataValid;
  logic       pwm_out;
  logic       update_pending;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_regbank #(.REGBITS(2), .CNTBITS(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .regAddr        (regAddr),
    .regData        (regData),
    .regDataValid   (regDataValid),
    .pwm_out        (pwm_out),
    .update_pending (update_pending),
    .period_start   (period_start)
  );

  // Presented at a negedge, sampled at the next posedge; returns at the following negedge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    regAddr      = a;
    regData      = d;
    regDataValid = 1'b1;
    @(negedge clk);
    regDataValid = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; regDataValid = 1'b0; regAddr = 2'd0; regData = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_out, update_pending, period_start} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000", {pwm_out, update_pending, period_start});
    end
    rst = 1'b0;
    regAddr = 2'd3; regData = 8'h81;
    repeat (4) @(negedge clk);
    checks++;
    if (update_pending !== 1'b0) begin
      errors++; $display("FAIL ignore_invalid: pending got %b expected 0", update_pending);
    end
    wr(2'd3, 8'h01);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || update_pending !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_defaults_run: %0d bad samples, expected 0 (pwm and pending low)", bad);
    end
    wr(2'd3, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad, bad_ps;
    logic exp_ps;
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h40);
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h81);
    checks++;
    if (update_pending !== 1'b0) begin
      errors++; $display("FAIL idle_commit_pending: got %b expected 0", update_pending);
    end
    bad = 0; bad_ps = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (pwm_out !== ((i % 256) < 64)) bad++;
`ifdef PWM_PERIOD_START_EN
      exp_ps = (i == 256);
`else
      exp_ps = 1'b0;
`endif
      if (period_start !== exp_ps) bad_ps++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL basic_duty64: %0d bad pwm samples, expected 0", bad);
    end
    checks++;
    if (bad_ps !== 0) begin
      errors++; $display("FAIL period_start_pulse: %0d bad samples, expected 0", bad_ps);
    end
  endtask

  task automatic test_pending();
    int bad, bad_p;
    repeat (10) @(negedge clk);
    wr(2'd0, 8'h80);
    wr(2'd3, 8'h81);
    checks++;
    if (update_pending !== 1'b1) begin
      errors++; $display("FAIL pending_set: got %b expected 1", update_pending);
    end
    bad = 0; bad_p = 0;
    for (int c = 12; c < 256; c++) begin
      @(negedge clk);
      if (pwm_out !== (c < 64)) bad++;
      if (update_pending !== (c != 255)) bad_p++;
    end
    checks++;
    if (bad !== 0 || bad_p !== 0) begin
      errors++; $display("FAIL pending_current_period: pwm bad %0d pending bad %0d, expected 0 0", bad, bad_p);
    end
    bad = 0; bad_p = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (pwm_out !== (c < 128)) bad++;
      if (update_pending !== 1'b0) bad_p++;
    end
    checks++;
    if (bad !== 0 || bad_p !== 0) begin
      errors++; $display("FAIL pending_next_period: pwm bad %0d pending bad %0d, expected 0 0", bad, bad_p);
    end
  endtask

  task automatic test_commit_at_wrap();
    int bad, bad_p;
    wr(2'd0, 8'h20);
    repeat (254) @(negedge clk);
    wr(2'd3, 8'h81);
    checks++;
    if (update_pending !== 1'b1) begin
      errors++; $display("FAIL wrap_commit_pending: got %b expected 1", update_pending);
    end
    bad = 0; bad_p = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (pwm_out !== (c < 128)) bad++;
      if (update_pending !== (c != 255)) bad_p++;
    end
    checks++;
    if (bad !== 0 || bad_p !== 0) begin
      errors++; $display("FAIL wrap_commit_deferred: pwm bad %0d pending bad %0d, expected 0 0", bad, bad_p);
    end
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (pwm_out !== (c < 32) || update_pending !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL wrap_commit_applied: %0d bad samples, expected 0", bad);
    end
  endtask

  task automatic test_full_duty_invert();
    int bad;
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h01);
    wr(2'd3, 8'h81);
    repeat (253) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (pwm_out !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL duty_over_period: %0d samples not 1, expected 0", bad);
    end
    wr(2'd3, 8'h03);
    @(negedge clk);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL invert_full: %0d samples not 0, expected 0", bad);
    end
    wr(2'd3, 8'h00);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || update_pending !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL disable_idle: %0d bad samples, expected 0", bad);
    end
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h40);
    wr(2'd3, 8'h81);
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (pwm_out !== (c < 64) || period_start !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL restart_full_period: %0d bad samples, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    wr(2'd0, 8'h80);
    wr(2'd3, 8'h81);
    checks++;
    if ({pwm_out, update_pending} !== 2'b11) begin
      errors++; $display("FAIL premid_reset_state: got %b expected 11", {pwm_out, update_pending});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pwm_out, update_pending, period_start} !== 3'b000) begin
      errors++; $display("FAIL async_reset: got %b expected 000", {pwm_out, update_pending, period_start});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_out, update_pending} !== 2'b00) begin
      errors++; $display("FAIL post_reset_idle: got %b expected 00", {pwm_out, update_pending});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_commit_at_wrap();
    test_full_duty_invert();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_regbank.md
Name: pwm_regbank

Overview:
- Downstream consumer of the I2C register-write interface.
- Latches single-cycle register writes (addr, data, valid) into shadow registers.
- Commits duty and period to the active set only at a PWM period boundary, so the output never glitches mid-period.
- Drives one PWM output from a free-running period counter; this is the block the I2C front end programs.

Parameters:
- REGBITS, 2, register address width; must be >= 2; addresses >= 4 are ignored.
- CNTBITS, 16, width of the PWM counter, duty and period (fixed 16; upper/lower bytes map to registers).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- regAddr  in  REGBITS  register address, qualified by regDataValid
- regData  in  8  register write data, qualified by regDataValid
- regDataValid  in  1  single-cycle write strobe
- pwm_out  out  1  PWM output, registered
- update_pending  out  1  commit armed, not yet applied
- period_start  out  1  one-cycle pulse when the counter wraps to 0 (see Optional Feature)

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk, all state on posedge clk.
- Register map (write-only):
  - 0 DUTY_LO: shadow_duty[7:0].
  - 1 DUTY_HI: shadow_duty[15:8].
  - 2 PER_HI: shadow_period = {data, 8'hFF}.
  - 3 CTRL: bit0 enable, bit1 invert (both take effect the next cycle); bit7 commit (arms an update, self-clearing, never stored).
- Writes land one clk after regDataValid is sampled high. regAddr/regData are ignored when valid is low.
- Reset values:
  - shadow_duty = active_duty = 0.
  - shadow_period = active_period = 16'hFFFF.
  - enable = 0, invert = 0, cnt = 0, update_pending = 0, pwm_out = 0, period_start = 0.
- States: IDLE (enable = 0) and RUN (enable = 1).
- IDLE:
  - cnt held at 0; pwm_out = invert.
  - A pending commit applies on the next clk: active <= shadow, update_pending <= 0.
- RUN:
  - cnt increments each clk. When cnt == active_period, cnt <= 0 (wrap).
  - At the wrap edge, if update_pending: active_duty/active_period <= shadow, update_pending <= 0. The new values govern the period starting at cnt = 0.
- Output: pwm_out <= (cnt < active_duty) ^ invert, registered, one clk latency from cnt.
  - duty = 0 gives constant 0 (before invert).
  - duty > period gives constant 1 (100%).
- IDLE -> RUN: cnt starts at 0 on the cycle after enable is written; the first period is full length.
- RUN -> IDLE: cnt is forced to 0 on the next clk and the output goes idle immediately; there is no waiting for the period end.
- Simultaneous commit write and wrap in the same cycle: the commit is not taken at this wrap. update_pending sets and the commit applies at the next wrap.
- Shadow writes while pending: the latest shadow values at the wrap edge are the ones committed.
- A second commit while pending is a no-op; pending stays 1.
- Shrinking the period below the current cnt can only happen at a wrap (cnt = 0), so there is no overrun. Active values never change mid-period.
- Reset mid-period: everything returns to reset values asynchronously; pwm_out = 0.

Optional Feature:
- Macro PWM_PERIOD_START_EN.
- Defined: period_start is a registered one-clk pulse, asserted on the cycle in which cnt == 0 following a wrap, aligned with pwm_out. It is not pulsed in IDLE.
- Undefined: period_start is tied to 0 and no extra logic is built.

Test Plan:
- Reset -> pwm_out = 0, update_pending = 0; with enable = 1 and no commit, the active period is 0xFFFF and duty is 0, so pwm_out stays 0.
- Write PER_HI = 0x00, DUTY_LO = 0x40, DUTY_HI = 0x00, CTRL = 0x81 -> commit applies while in IDLE (enable was 0 before the write); pwm_out high for 64 of every 256 clks.
- While running duty = 0x40 / period = 0x00FF:
  - Write DUTY_LO = 0x80 and CTRL = 0x81 mid-period -> update_pending = 1 until the wrap.
  - The current period is still 64 high; the next period is 128 high; pending clears at the wrap.
- Commit write strobed in the same cycle as cnt == 0x00FF -> not applied at that wrap; applied at the following wrap (256 clks later).
- DUTY = 0x0100 with period 0x00FF -> pwm_out constant 1. Then CTRL = 0x03 (invert) -> constant 0. Then CTRL = 0x00 -> pwm_out = 0 and cnt = 0 next clk.
- Assert rst mid-period with pending set -> all outputs 0 and pending cleared immediately. With PWM_PERIOD_START_EN, period_start pulses exactly once per 256 clks in the run case.
